// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters with HSYNC/VSYNC/VIDEO_ON decode.
// Latency: 2 CLK from a VGA_CLK rising edge to outputs (1 counter update, 1 output register).
// Backpressure: none; free-running. It advances only on VGA_CLK rising edges seen in the CLK domain.
//
// Ports:
//   CLK         - system clock. All flops use its rising edge.
//   RST         - asynchronous, active-high reset.
//   VGA_CLK     - pixel-rate level from the clock divider (same CLK domain). It is sampled, not used as a clock.
//   HSYNC/VSYNC - active-low sync pulses.
//   VIDEO_ON    - current pixel lies in the visible area.
//   X/Y         - current pixel/line position, zero-extended to 10 bits.
//   FRAME_START - one-CLK pulse, aligned with the first output cycle at (0,0).
//
// Counters are 10 bits wide, so H_TOT and V_TOT must not exceed 1024.

module vga_sync_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VGA_CLK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VIDEO_ON,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       FRAME_START
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    // Counter stage
    logic       vga_prev_q,    vga_prev_d;
    logic [9:0] hcnt_q,        hcnt_d;
    logic [9:0] vcnt_q,        vcnt_d;
    logic       frame_wrap_q,  frame_wrap_d;

    // Output stage
    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       video_on_q,    video_on_d;
    logic [9:0] x_q,           x_d;
    logic [9:0] y_q,           y_d;
    logic       frame_start_q, frame_start_d;

    logic pixel_tick;
    logic h_at_end;
    logic v_at_end;

    always_comb begin
        // vga_prev resets to 1, so a VGA_CLK that is already high at
        // reset release is not seen as a rising edge.
        pixel_tick   = VGA_CLK & ~vga_prev_q;
        vga_prev_d   = VGA_CLK;
        h_at_end     = (hcnt_q == H_LAST);
        v_at_end     = (vcnt_q == V_LAST);

        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        if (pixel_tick) begin
            if (h_at_end) begin
                hcnt_d = '0;
                vcnt_d = v_at_end ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end

        // Marks the counters entering (0,0). It is delayed one more stage
        // so the pulse lines up with X=0, Y=0 on the outputs.
        frame_wrap_d = pixel_tick & h_at_end & v_at_end;
    end

    always_comb begin
        hsync_d       = ~((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
        vsync_d       = ~((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
        video_on_d    = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
        x_d           = hcnt_q;
        y_d           = vcnt_q;
        frame_start_d = frame_wrap_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vga_prev_q    <= 1'b1;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_wrap_q  <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            vga_prev_q    <= vga_prev_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_wrap_q  <= frame_wrap_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign VIDEO_ON    = video_on_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    typedef struct packed {
        int hv, hf, hs, hb, vv, vf, vs, vb;
    } tim_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } out_t;

    typedef struct packed {
        out_t d0;
        out_t d1;
    } pair_t;

    typedef struct packed {
        int         ticks;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
    } vec_t;

    // Standard 640x480 timing and a tiny timing for whole-frame checks.
    localparam tim_t T0 = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam tim_t T1 = '{8, 2, 3, 2, 4, 1, 2, 1};
    localparam out_t RST_OUT = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};

    logic       CLK;
    logic       RST;
    logic       VGA_CLK;
    logic       HSYNC, VSYNC, VIDEO_ON, FRAME_START;
    logic [9:0] X, Y;
    logic       s_hsync, s_vsync, s_video_on, s_frame_start;
    logic [9:0] s_x, s_y;

    vga_sync_gen #(
        .H_VIS(T0.hv), .H_FP(T0.hf), .H_SYNC(T0.hs), .H_BP(T0.hb),
        .V_VIS(T0.vv), .V_FP(T0.vf), .V_SYNC(T0.vs), .V_BP(T0.vb)
    ) dut (
        .CLK(CLK), .RST(RST), .VGA_CLK(VGA_CLK),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .VIDEO_ON(VIDEO_ON),
        .X(X), .Y(Y), .FRAME_START(FRAME_START)
    );

    vga_sync_gen #(
        .H_VIS(T1.hv), .H_FP(T1.hf), .H_SYNC(T1.hs), .H_BP(T1.hb),
        .V_VIS(T1.vv), .V_FP(T1.vf), .V_SYNC(T1.vs), .V_BP(T1.vb)
    ) dut_s (
        .CLK(CLK), .RST(RST), .VGA_CLK(VGA_CLK),
        .HSYNC(s_hsync), .VSYNC(s_vsync), .VIDEO_ON(s_video_on),
        .X(s_x), .Y(s_y), .FRAME_START(s_frame_start)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int    n_pass = 0;
    int    n_tot  = 0;
    int    mh [2];
    int    mv [2];
    bit    mfw [2];
    bit    mprev;
    pair_t sbq [$];
    vec_t  tbl [11];

    function automatic out_t dec(input tim_t t, input int h, input int v, input bit fw);
        out_t o;
        o.hs  = !((h >= t.hv + t.hf) && (h < t.hv + t.hf + t.hs));
        o.vs  = !((v >= t.vv + t.vf) && (v < t.vv + t.vf + t.vs));
        o.von = (h < t.hv) && (v < t.vv);
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.fs  = fw;
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic chk_out(input string name, input out_t act, input out_t exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got hs=%b vs=%b von=%b x=%0d y=%0d fs=%b, expected hs=%b vs=%b von=%b x=%0d y=%0d fs=%b at t=%0t",
                      name, act.hs, act.vs, act.von, act.x, act.y, act.fs,
                      exp.hs, exp.vs, exp.von, exp.x, exp.y, exp.fs, $time);
    endtask

    task automatic model_reset();
        mh[0] = 0; mh[1] = 0;
        mv[0] = 0; mv[1] = 0;
        mfw[0] = 0; mfw[1] = 0;
        mprev = 1'b1;
    endtask

    // One CLK: drive VGA_CLK, advance the model at the rising edge and push
    // the expected outputs, then pop and compare at the falling edge.
    task automatic cycle(input logic v);
        pair_t e;
        pair_t p;
        tim_t  t;
        bit    tk;
        int    ht, vt;
        VGA_CLK = v;
        @(posedge CLK);
        if (RST) begin
            e.d0 = RST_OUT;
            e.d1 = RST_OUT;
            model_reset();
        end else begin
            e.d0 = dec(T0, mh[0], mv[0], mfw[0]);
            e.d1 = dec(T1, mh[1], mv[1], mfw[1]);
            tk = v && !mprev;
            mprev = v;
            for (int i = 0; i < 2; i++) begin
                t  = (i == 0) ? T0 : T1;
                ht = t.hv + t.hf + t.hs + t.hb;
                vt = t.vv + t.vf + t.vs + t.vb;
                mfw[i] = tk && (mh[i] == ht - 1) && (mv[i] == vt - 1);
                if (tk) begin
                    if (mh[i] == ht - 1) begin
                        mh[i] = 0;
                        mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
                    end else begin
                        mh[i] = mh[i] + 1;
                    end
                end
            end
        end
        sbq.push_back(e);
        @(negedge CLK);
        p = sbq.pop_front();
        chk_out("sb_std", {HSYNC, VSYNC, VIDEO_ON, X, Y, FRAME_START}, p.d0);
        chk_out("sb_small", {s_hsync, s_vsync, s_video_on, s_x, s_y, s_frame_start}, p.d1);
    endtask

    task automatic tick();
        cycle(1'b0);
        cycle(1'b1);
    endtask

    initial begin
        int low_cnt;
        int first_low;
        int fs_cnt;
        int vs_low;
        logic v;

        // Checkpoints on the standard timing, cumulative ticks from reset.
        tbl[0]  = '{0,   10'd0,   10'd0, 1'b1, 1'b1};
        tbl[1]  = '{1,   10'd1,   10'd0, 1'b1, 1'b1};
        tbl[2]  = '{1,   10'd2,   10'd0, 1'b1, 1'b1};
        tbl[3]  = '{637, 10'd639, 10'd0, 1'b1, 1'b1};
        tbl[4]  = '{1,   10'd640, 10'd0, 1'b0, 1'b1};
        tbl[5]  = '{15,  10'd655, 10'd0, 1'b0, 1'b1};
        tbl[6]  = '{1,   10'd656, 10'd0, 1'b0, 1'b0};
        tbl[7]  = '{95,  10'd751, 10'd0, 1'b0, 1'b0};
        tbl[8]  = '{1,   10'd752, 10'd0, 1'b0, 1'b1};
        tbl[9]  = '{47,  10'd799, 10'd0, 1'b0, 1'b1};
        tbl[10] = '{1,   10'd0,   10'd1, 1'b1, 1'b1};

        RST = 1'b1;
        VGA_CLK = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        chk_out("reset_std", {HSYNC, VSYNC, VIDEO_ON, X, Y, FRAME_START}, RST_OUT);
        chk_out("reset_small", {s_hsync, s_vsync, s_video_on, s_x, s_y, s_frame_start}, RST_OUT);

        // Release with VGA_CLK high: no tick may result.
        RST = 1'b0;
        for (int i = 0; i < 11; i++) begin
            repeat (tbl[i].ticks) tick();
            cycle(1'b1);
            chk($sformatf("tbl%0d_x", i),   int'(X),    int'(tbl[i].x));
            chk($sformatf("tbl%0d_y", i),   int'(Y),    int'(tbl[i].y));
            chk($sformatf("tbl%0d_von", i), int'(VIDEO_ON), int'(tbl[i].von));
            chk($sformatf("tbl%0d_hs", i),  int'(HSYNC), int'(tbl[i].hs));
            chk($sformatf("tbl%0d_vs", i),  int'(VSYNC), 1);
            chk($sformatf("tbl%0d_fs", i),  int'(FRAME_START), 0);
        end

        // Line 1: HSYNC low for 96 pixel positions starting at X=656.
        low_cnt = 0;
        first_low = -1;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (HSYNC == 1'b0) begin
                if (first_low < 0) first_low = int'(X);
                low_cnt++;
            end
        end
        chk("hsync_low_ticks", low_cnt, 96);
        chk("hsync_first_x", first_low, 656);
        cycle(1'b1);
        chk("line_wrap_x", int'(X), 0);
        chk("line_wrap_y", int'(Y), 2);

        // VGA_CLK frozen high then low: no movement, then exactly one step.
        repeat (50) cycle(1'b1);
        chk("hold_high_x", int'(X), 0);
        repeat (50) cycle(1'b0);
        chk("hold_low_x", int'(X), 0);
        cycle(1'b1);
        cycle(1'b1);
        chk("hold_release_x", int'(X), 1);
        chk("hold_release_y", int'(Y), 2);

        // Two whole frames of the small timing (120 ticks each).
        fs_cnt = 0;
        vs_low = 0;
        v = 1'b0;
        for (int i = 0; i < 480; i++) begin
            cycle(v);
            if (s_frame_start) begin
                fs_cnt++;
                chk("fs_at_x0", int'(s_x), 0);
                chk("fs_at_y0", int'(s_y), 0);
            end
            if (v && !s_vsync) vs_low++;
            v = ~v;
        end
        chk("frame_start_pulses", fs_cnt, 2);
        chk("vsync_low_ticks", vs_low, 60);

        // Move the standard timing to X=700 (inside HSYNC), then reset mid-line.
        repeat (459) tick();
        cycle(1'b1);
        chk("pre_rst_x", int'(X), 700);
        chk("pre_rst_hs", int'(HSYNC), 0);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_hs", int'(HSYNC), 1);
        chk("async_rst_x", int'(X), 0);
        chk("async_rst_y", int'(Y), 0);
        chk("async_rst_von", int'(VIDEO_ON), 0);
        chk("async_rst_small_x", int'(s_x), 0);
        @(negedge CLK);
        repeat (2) cycle(1'b1);
        RST = 1'b0;
        repeat (3) cycle(1'b1);
        chk("post_rst_x", int'(X), 0);
        chk("post_rst_von", int'(VIDEO_ON), 1);
        chk("post_rst_fs", int'(FRAME_START), 0);
        tick();
        cycle(1'b1);
        chk("post_rst_step_x", int'(X), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
